sher_vi_ctrl_fsm: RTL and testbench

- Multi-cycle Moore control unit for the 16-bit SHER VI memory-to-memory processor.
- Sequences each instruction: fetch, operand read, execute, then writeback / pointer update / branch.
- Decodes the 5-bit opcode field IRO[4:0] and drives all datapath enables and mux selects.
- Sits between the instruction register and the datapath (PC, SP, TSP, A/B/C, ALUOUT, CMP, memory).

---
 rtl/sher_vi_pkg.sv | 60 ++++++
 rtl/sher_vi_ctrl_outdec.sv | 50 +++++
 rtl/sher_vi_ctrl_fsm.sv | 96 +++++++++
 tb/tb_sher_vi_ctrl_fsm.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/sher_vi_pkg.sv
// Shared types and constants for the SHER VI multi-cycle control unit.
// Optional halt support is enabled by defining SHER_VI_HALT_EN.
package sher_vi_pkg;

   typedef enum logic [3:0] {
      ST_FETCH  = 4'd0,
      ST_DECODE = 4'd1,
      ST_EXEC   = 4'd2,
      ST_ALU_WB = 4'd3,
      ST_CMP_WB = 4'd4,
      ST_PTR    = 4'd5,
      ST_PTR_SP = 4'd6,
      ST_LI     = 4'd7,
      ST_BR     = 4'd8,
      ST_HALT   = 4'd9
   } state_e;

   localparam logic [1:0] CLS_ALU    = 2'b00;
   localparam logic [1:0] CLS_PTR    = 2'b01;
   localparam logic [1:0] CLS_LI     = 2'b10;
   localparam logic [1:0] CLS_BR     = 2'b11;
   localparam logic [2:0] CMP_F3_MIN = 3'b110;
   localparam logic [4:0] HALT_CODE  = 5'b10011;

   typedef struct packed {
      logic       halted;
      logic       common;
      logic       spwrite;
      logic       tspwrite;
      logic       writezero;
      logic       memwrite;
      logic       skipcmp;
      logic       generic;
      logic [1:0] datain;
   } ctrl_t;

   // Funct3 values at or above the threshold are compares, written back only if CMP.
   function automatic logic is_cmp(input logic [2:0] f3);
      return (f3 >= CMP_F3_MIN);
   endfunction

   function automatic state_e decode_next(input logic [4:0] op);
      state_e nxt;
      case (op[1:0])
         CLS_ALU: nxt = ST_EXEC;
         CLS_PTR: begin
            case (op[4:3])
               2'b00:   nxt = ST_PTR;
               2'b01:   nxt = ST_PTR_SP;
               default: nxt = ST_FETCH;
            endcase
         end
         CLS_LI:  nxt = ST_LI;
         CLS_BR:  nxt = ST_EXEC;
         default: nxt = ST_FETCH;
      endcase
      return nxt;
   endfunction

endpackage

// File: rtl/sher_vi_ctrl_outdec.sv
// Moore output table: maps the FSM state onto the datapath control vector.
module sher_vi_ctrl_outdec
   import sher_vi_pkg::*;
(
   input  state_e state_i,
   output ctrl_t  ctrl_o
);

   // State-to-control lookup; anything not listed stays inactive.
   always_comb begin
      ctrl_o = '0;
      case (state_i)
         ST_FETCH: begin
            ctrl_o.common  = 1'b1;
            ctrl_o.generic = 1'b1;
            ctrl_o.skipcmp = 1'b1;
         end
         ST_DECODE: ctrl_o.generic = 1'b1;
         ST_EXEC:   ctrl_o = '0;
         ST_ALU_WB: begin
            ctrl_o.memwrite = 1'b1;
            ctrl_o.skipcmp  = 1'b1;
            ctrl_o.datain   = 2'b01;
         end
         ST_CMP_WB: begin
            ctrl_o.memwrite = 1'b1;
            ctrl_o.datain   = 2'b01;
         end
         ST_PTR:    ctrl_o.tspwrite = 1'b1;
         ST_PTR_SP: begin
            ctrl_o.tspwrite = 1'b1;
            ctrl_o.spwrite  = 1'b1;
            ctrl_o.skipcmp  = 1'b1;
         end
         ST_LI: begin
            ctrl_o.memwrite = 1'b1;
            ctrl_o.skipcmp  = 1'b1;
            ctrl_o.datain   = 2'b00;
         end
         ST_BR: begin
            ctrl_o.common    = 1'b1;
            ctrl_o.writezero = 1'b1;
            ctrl_o.datain    = 2'b10;
         end
         ST_HALT:   ctrl_o.halted = 1'b1;
         default:   ctrl_o = '0;
      endcase
   end

endmodule

// File: rtl/sher_vi_ctrl_fsm.sv
// SHER VI control FSM: fetch/decode/execute/writeback sequencing.
// Define SHER_VI_HALT_EN to add the HALT opcode and the halted output.
module sher_vi_ctrl_fsm
   import sher_vi_pkg::*;
#(
   parameter int CODE_W = 5
) (
   input  logic              CLK,
   input  logic              Reset,
   input  logic [CODE_W-1:0] code,
   output logic              COMMON,
   output logic              SPWRITE,
   output logic              TSPWRITE,
   output logic              WRITEZERO,
   output logic              MEMWRITE,
   output logic              SKIPCMP,
   output logic              GENERIC,
`ifdef SHER_VI_HALT_EN
   output logic              halted,
`endif
   output logic [1:0]        DATAIN
);

   state_e      state_q;
   logic [4:0]  op_q;
   ctrl_t       dec_s;
   ctrl_t       ctrl_s;

   // State register and next-state logic; the opcode is captured in DECODE only.
   always_ff @(posedge CLK) begin
      if (!Reset) begin
         state_q <= ST_FETCH;
         op_q    <= 5'b00000;
      end else begin
         case (state_q)
            ST_FETCH:  state_q <= ST_DECODE;
            ST_DECODE: begin
               op_q <= code;
`ifdef SHER_VI_HALT_EN
               if (code == HALT_CODE) begin
                  state_q <= ST_HALT;
               end else begin
                  state_q <= decode_next(code);
               end
`else
               state_q <= decode_next(code);
`endif
            end
            ST_EXEC: begin
               if (op_q[1:0] == CLS_BR) begin
                  state_q <= ST_BR;
               end else if (op_q[1:0] == CLS_ALU) begin
                  state_q <= is_cmp(op_q[4:2]) ? ST_CMP_WB : ST_ALU_WB;
               end else begin
                  state_q <= ST_FETCH;
               end
            end
`ifdef SHER_VI_HALT_EN
            ST_HALT:   state_q <= ST_HALT;
`endif
            default:   state_q <= ST_FETCH;
         endcase
      end
   end

   sher_vi_ctrl_outdec u_outdec (
      .state_i (state_q),
      .ctrl_o  (dec_s)
   );

   // Reset blanks every control line so an aborted instruction cannot write.
   always_comb begin
      if (!Reset) begin
         ctrl_s = '0;
      end else begin
         ctrl_s = dec_s;
      end
   end

   assign COMMON    = ctrl_s.common;
   assign SPWRITE   = ctrl_s.spwrite;
   assign TSPWRITE  = ctrl_s.tspwrite;
   assign WRITEZERO = ctrl_s.writezero;
   assign MEMWRITE  = ctrl_s.memwrite;
   assign SKIPCMP   = ctrl_s.skipcmp;
   assign GENERIC   = ctrl_s.generic;
   assign DATAIN    = ctrl_s.datain;

`ifdef SHER_VI_HALT_EN
   assign halted = ctrl_s.halted;
`else
   logic unused_halted_s;
   assign unused_halted_s = ctrl_s.halted;
`endif

endmodule

// File: tb/tb_sher_vi_ctrl_fsm.sv
// Randomized bench for sher_vi_ctrl_fsm against a per-instruction output-sequence model.
module tb_sher_vi_ctrl_fsm;

   logic       CLK = 1'b0;
   logic       Reset = 1'b0;
   logic [4:0] code = 5'b00000;
   logic       COMMON, SPWRITE, TSPWRITE, WRITEZERO, MEMWRITE, SKIPCMP, GENERIC;
   logic [1:0] DATAIN;
`ifdef SHER_VI_HALT_EN
   logic       halted;
`else
   logic       halted = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   // Expected output vectors {halted, COMMON, SPWRITE, TSPWRITE, WRITEZERO, MEMWRITE, SKIPCMP, GENERIC, DATAIN}
   localparam logic [9:0] V_ZERO   = 10'h000;
   localparam logic [9:0] V_FETCH  = 10'h10C;
   localparam logic [9:0] V_DECODE = 10'h004;
   localparam logic [9:0] V_EXEC   = 10'h000;
   localparam logic [9:0] V_ALUWB  = 10'h019;
   localparam logic [9:0] V_CMPWB  = 10'h011;
   localparam logic [9:0] V_PTR    = 10'h040;
   localparam logic [9:0] V_PTRSP  = 10'h0C8;
   localparam logic [9:0] V_LI     = 10'h018;
   localparam logic [9:0] V_BR     = 10'h122;
   localparam logic [9:0] V_HALT   = 10'h200;

   logic [9:0] exp_q[$];

   sher_vi_ctrl_fsm #(.CODE_W(5)) dut (
      .CLK       (CLK),
      .Reset     (Reset),
      .code      (code),
      .COMMON    (COMMON),
      .SPWRITE   (SPWRITE),
      .TSPWRITE  (TSPWRITE),
      .WRITEZERO (WRITEZERO),
      .MEMWRITE  (MEMWRITE),
      .SKIPCMP   (SKIPCMP),
      .GENERIC   (GENERIC),
`ifdef SHER_VI_HALT_EN
      .halted    (halted),
`endif
      .DATAIN    (DATAIN)
   );

   always #5 CLK = ~CLK;

   function automatic logic [9:0] obs_vec();
      return {halted, COMMON, SPWRITE, TSPWRITE, WRITEZERO, MEMWRITE, SKIPCMP, GENERIC, DATAIN};
   endfunction

   task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Per-cycle output sequence of one instruction, straight from the opcode class rules.
   function automatic void build_expect(input logic [4:0] c);
      exp_q.delete();
      exp_q.push_back(V_FETCH);
      exp_q.push_back(V_DECODE);
      case (c[1:0])
         2'b00: begin
            exp_q.push_back(V_EXEC);
            exp_q.push_back((int'(c[4:2]) >= 6) ? V_CMPWB : V_ALUWB);
         end
         2'b01: begin
            if (c[4:3] == 2'b00) exp_q.push_back(V_PTR);
            else if (c[4:3] == 2'b01) exp_q.push_back(V_PTRSP);
            else exp_q.push_back(V_FETCH);
         end
         2'b10: exp_q.push_back(V_LI);
         default: begin
            exp_q.push_back(V_EXEC);
            exp_q.push_back(V_BR);
         end
      endcase
      // The no-op pointer case ends after DECODE, so the trailing FETCH belongs to the next instruction.
      if (exp_q[exp_q.size()-1] == V_FETCH) exp_q.pop_back();
   endfunction

   // Runs one instruction; code is valid only in DECODE and scrambled elsewhere.
   task automatic run_instr(input logic [4:0] c);
      build_expect(c);
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i == 1) code = c;
         else code = 5'($urandom);
         check_eq($sformatf("op%b_step%0d", c, i), obs_vec(), exp_q[i]);
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      logic [4:0] c;
      logic [4:0] dir_codes[7];
      dir_codes = '{5'b00000, 5'b11000, 5'b01001, 5'b10001, 5'b00011, 5'b00101, 5'b00010};

      Reset = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(posedge CLK); #1;
         code = 5'($urandom);
         check_eq($sformatf("reset_hold%0d", i), obs_vec(), V_ZERO);
      end
      Reset = 1'b1;
      #1;

      foreach (dir_codes[i]) run_instr(dir_codes[i]);

      for (int n = 0; n < 150; n++) begin
         c = 5'($urandom);
`ifdef SHER_VI_HALT_EN
         if (c == 5'b10011) c = 5'b00000;
`endif
         run_instr(c);
      end

      // Abort an add while it sits in ALU_WB.
      build_expect(5'b00000);
      for (int i = 0; i < 3; i++) begin
         code = (i == 1) ? 5'b00000 : 5'($urandom);
         check_eq($sformatf("abort_step%0d", i), obs_vec(), exp_q[i]);
         @(posedge CLK); #1;
      end
      check_eq("abort_aluwb", obs_vec(), V_ALUWB);
      Reset = 1'b0;
      #1;
      check_eq("abort_rst_cycle", obs_vec(), V_ZERO);
      @(posedge CLK); #1;
      Reset = 1'b1;
      #1;
      run_instr(5'b11100);
      run_instr(5'b00010);

`ifdef SHER_VI_HALT_EN
      check_eq("halt_fetch", obs_vec(), V_FETCH);
      @(posedge CLK); #1;
      code = 5'b10011;
      check_eq("halt_decode", obs_vec(), V_DECODE);
      @(posedge CLK); #1;
      for (int i = 0; i < 20; i++) begin
         code = 5'($urandom);
         check_eq($sformatf("halt_hold%0d", i), obs_vec(), V_HALT);
         @(posedge CLK); #1;
      end
      Reset = 1'b0;
      #1;
      check_eq("halt_rst", obs_vec(), V_ZERO);
      @(posedge CLK); #1;
      Reset = 1'b1;
      #1;
      run_instr(5'b01000);
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
